hanoi_move_gen: RTL and testbench
=================================

Name: hanoi_move_gen

Overview:
- Parametrised Towers of Hanoi move generator; successor to the fixed five-disk ripple tower.
- On `start`, emits the optimal 2^NUM_DISKS-1 move sequence, one move per valid/ready handshake, then pulses `done`.
- Tracks each disk's peg internally, so source and destination pegs are configurable.
- Sits between the start-button debounce logic and any downstream move consumer (display, logger, checker).

Parameters:
- NUM_DISKS, 5, disk count, legal range 1..15; the move index is NUM_DISKS bits wide.
- SRC_PEG, 1, starting peg, 1..3.
- DST_PEG, 3, target peg, 1..3, != SRC_PEG; AUX = 6 - SRC_PEG - DST_PEG.

Ports:
- clk  input  1  clock, all logic on posedge
- reset  input  1  synchronous, active-high
- start  input  1  single-cycle request to begin a sequence
- mv_valid  output  1  move presented
- mv_ready  input  1  consumer accepts move
- mv_from  output  2  source peg, 1..3 (0 when idle)
- mv_to  output  2  destination peg, 1..3 (0 when idle)
- mv_disk  output  4  disk moved, 0 = smallest
- mv_index  output  NUM_DISKS  move number k, 1..2^NUM_DISKS-1
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse after final move accepted
- illegal  output  1  sticky rule-violation flag (see Optional Feature)

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values:
  - state = IDLE; mv_valid, busy, done, illegal = 0.
  - mv_from, mv_to, mv_disk, mv_index = 0.
  - Every disk's peg register = SRC_PEG.
- States: IDLE, RUN, FIN.
- IDLE:
  - `start`=1 at edge t: load k=1, reinitialise all disk pegs to SRC_PEG, go to RUN.
  - mv_valid=1 and busy=1 from cycle t+1.
- RUN, current move k:
  - mv_disk = number of trailing zeros of k.
  - mv_from = peg[mv_disk].
  - mv_to = next peg in that disk's cycle:
    - if (NUM_DISKS - mv_disk) is odd: SRC->DST->AUX->SRC;
    - otherwise: SRC->AUX->DST->SRC.
  - mv_index = k.
- Handshake:
  - A move transfers on an edge where mv_valid & mv_ready.
  - Outputs are held stable while mv_ready=0; stalls are unbounded.
  - On transfer: peg[mv_disk] <= mv_to; k <= k+1.
  - The next move is valid on the following cycle, so back-to-back throughput is 1 move/cycle.
- Final move: transfer of k = 2^NUM_DISKS-1 moves to FIN.
  - In the next cycle: mv_valid=0, done=1 for exactly one cycle, busy=0, payload outputs = 0.
  - Then return to IDLE.
- After completion, all disk peg registers = DST_PEG.
- `start` while in RUN or FIN is ignored; no restart and no queueing.
- `start` and `reset` asserted together: reset wins.
- Reset mid-sequence: the next cycle is the reset state; no done pulse; the partial sequence is discarded.
- Arithmetic:
  - k never wraps inside a sequence.
  - Trailing-zero count is a priority encoder over k; k=0 never occurs in RUN.
- NUM_DISKS=1 is legal: a single move SRC->DST, then done.

Optional Feature:
- Macro: HANOI_CHECK_EN.
- When defined:
  - Per-peg occupancy bitmaps (NUM_DISKS bits each) are maintained.
  - On every transfer, `illegal` sets if:
    - bit mv_disk is not set on mv_from; or
    - mv_from has any smaller disk set; or
    - mv_to has any smaller disk set; or
    - mv_from == mv_to.
  - `illegal` stays set until reset.
  - A new `start` reinitialises the bitmaps to all disks on SRC_PEG, but does not clear `illegal`.
- When undefined: no bitmaps are built and `illegal` is tied 0.
- The port list is identical in both builds.

Test Plan:
- NUM_DISKS=3, defaults, mv_ready=1, start pulse at cycle 2:
  - Moves on cycles 3..9, (from->to, disk): 1->3 d0, 1->2 d1, 3->2 d0, 1->3 d2, 2->1 d0, 2->3 d1, 1->3 d0.
  - done=1 on cycle 10; busy 1 on 3..9; illegal=0.
- NUM_DISKS=2, SRC_PEG=2, DST_PEG=1:
  - Sequence 2->3 d0, 2->1 d1, 3->1 d0 (mv_index 1,2,3), then done.
- Backpressure, NUM_DISKS=3: drop mv_ready for 5 cycles during move k=4.
  - mv_from=1, mv_to=3, mv_disk=2, mv_index=4 stable throughout; the remaining sequence is unchanged.
- Reset at move k=10 of NUM_DISKS=5:
  - Next cycle: mv_valid=0, busy=0, no done.
  - A new start yields k=1 move 1->3 d0 (disk pegs reinitialised).
- NUM_DISKS=5: start re-pulsed at k=7 is ignored.
  - Exactly 31 transfers, done once; with HANOI_CHECK_EN, illegal=0.
- NUM_DISKS=1: start -> single move 1->3 d0, mv_index=1 -> done next cycle.
  - A second start is accepted afterwards and produces the same move.

Source files
------------

// File: rtl/hanoi_move_gen.sv
`default_nettype none
// ============================================================================
// Module   : hanoi_move_gen
// Purpose  : Towers of Hanoi move generator, one optimal move per handshake.
//            Define HANOI_CHECK_EN to add the peg-occupancy rule checker.
// Revision : 1.0 - initial release
// ============================================================================
module hanoi_move_gen #(
    parameter int NUM_DISKS = 5,
    parameter int SRC_PEG   = 1,
    parameter int DST_PEG   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 mv_valid,
    input  logic                 mv_ready,
    output logic [1:0]           mv_from,
    output logic [1:0]           mv_to,
    output logic [3:0]           mv_disk,
    output logic [NUM_DISKS-1:0] mv_index,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal
);

    localparam logic [1:0]           SRC     = 2'(SRC_PEG);
    localparam logic [1:0]           DST     = 2'(DST_PEG);
    localparam logic [1:0]           AUX     = 2'(6 - SRC_PEG - DST_PEG);
    localparam logic                 N_ODD   = 1'(NUM_DISKS % 2);
    localparam logic [NUM_DISKS-1:0] K_FIRST = NUM_DISKS'(1);
    localparam logic [NUM_DISKS-1:0] K_LAST  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t               state_q;
    logic [NUM_DISKS-1:0] k_q;
    logic [1:0]           peg_q [NUM_DISKS];
    logic                 valid_q;
    logic [1:0]           from_q;
    logic [1:0]           to_q;
    logic [3:0]           disk_q;
    logic                 busy_q;
    logic                 done_q;

    logic [NUM_DISKS-1:0] k_d;
    logic [1:0]           peg_d [NUM_DISKS];
    logic [3:0]           nxt_disk;
    logic [1:0]           nxt_from;
    logic [1:0]           nxt_to;
    logic                 xfer;
    logic                 launch;

    // Lowest set bit wins: the loop overwrites from the top down.
    function automatic logic [3:0] trailing_zeros(input logic [NUM_DISKS-1:0] k);
        logic [3:0] tz;
        tz = 4'd0;
        for (int i = NUM_DISKS - 1; i >= 0; i--) begin
            if (k[i]) tz = 4'(i);
        end
        return tz;
    endfunction

    function automatic logic [1:0] next_peg(input logic odd_dist, input logic [1:0] p);
        if (p == SRC) return odd_dist ? DST : AUX;
        if (p == DST) return odd_dist ? AUX : SRC;
        return odd_dist ? SRC : DST;
    endfunction

    // Pre-compute the move that follows this edge so all payload outputs are registered.
    always_comb begin
        xfer   = valid_q & mv_ready;
        launch = (state_q == S_IDLE) & start;
        k_d    = k_q;
        peg_d  = peg_q;
        if (launch) begin
            k_d = K_FIRST;
            for (int i = 0; i < NUM_DISKS; i++) peg_d[i] = SRC;
        end else if (xfer) begin
            k_d = k_q + K_FIRST;
            for (int i = 0; i < NUM_DISKS; i++) begin
                if (4'(i) == disk_q) peg_d[i] = to_q;
            end
        end
        nxt_disk = trailing_zeros(k_d);
        nxt_from = SRC;
        for (int i = 0; i < NUM_DISKS; i++) begin
            if (4'(i) == nxt_disk) nxt_from = peg_d[i];
        end
        nxt_to = next_peg(N_ODD ^ nxt_disk[0], nxt_from);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            valid_q <= 1'b0;
            from_q  <= 2'd0;
            to_q    <= 2'd0;
            disk_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_DISKS; i++) peg_q[i] <= SRC;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_RUN;
                        k_q     <= k_d;
                        peg_q   <= peg_d;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        from_q  <= nxt_from;
                        to_q    <= nxt_to;
                        disk_q  <= nxt_disk;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        peg_q <= peg_d;
                        if (k_q == K_LAST) begin
                            state_q <= S_FIN;
                            k_q     <= '0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            from_q  <= 2'd0;
                            to_q    <= 2'd0;
                            disk_q  <= 4'd0;
                        end else begin
                            k_q    <= k_d;
                            from_q <= nxt_from;
                            to_q   <= nxt_to;
                            disk_q <= nxt_disk;
                        end
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mv_valid = valid_q;
    assign mv_from  = from_q;
    assign mv_to    = to_q;
    assign mv_disk  = disk_q;
    assign mv_index = k_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef HANOI_CHECK_EN
    // Occupancy bitmaps indexed directly by peg number; entry 0 stays empty.
    logic [NUM_DISKS-1:0] occ_q [4];
    logic [NUM_DISKS-1:0] occ_from;
    logic [NUM_DISKS-1:0] occ_to;
    logic [NUM_DISKS-1:0] onehot;
    logic [NUM_DISKS-1:0] lowmask;
    logic                 violation;
    logic                 illegal_q;

    always_comb begin
        occ_from  = occ_q[from_q];
        occ_to    = occ_q[to_q];
        onehot    = K_FIRST << disk_q;
        lowmask   = onehot - K_FIRST;
        violation = ~|(occ_from & onehot) | (|(occ_from & lowmask))
                  | (|(occ_to & lowmask)) | (from_q == to_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
            for (int p = 0; p < 4; p++) occ_q[p] <= (2'(p) == SRC) ? K_LAST : '0;
        end else if (launch) begin
            for (int p = 0; p < 4; p++) occ_q[p] <= (2'(p) == SRC) ? K_LAST : '0;
        end else if (xfer) begin
            if (violation) illegal_q <= 1'b1;
            occ_q[from_q] <= occ_from & ~onehot;
            occ_q[to_q]   <= occ_to | onehot;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hanoi_move_gen.sv
`default_nettype none
// Directed bench for hanoi_move_gen: 3/2/5/1-disk instances with hand-derived moves.
module tb_hanoi_move_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // NUM_DISKS=3, default pegs
    logic rst3, st3, rdy3, v3, b3, dn3, il3;
    logic [1:0] f3, t3;
    logic [3:0] d3;
    logic [2:0] i3;
    // NUM_DISKS=2, SRC=2, DST=1
    logic rst2, st2, rdy2, v2, b2, dn2, il2;
    logic [1:0] f2, t2;
    logic [3:0] d2;
    logic [1:0] i2;
    // NUM_DISKS=5
    logic rst5, st5, rdy5, v5, b5, dn5, il5;
    logic [1:0] f5, t5;
    logic [3:0] d5;
    logic [4:0] i5;
    // NUM_DISKS=1
    logic rst1, st1, rdy1, v1, b1, dn1, il1;
    logic [1:0] f1, t1;
    logic [3:0] d1;
    logic [0:0] i1;

    hanoi_move_gen #(.NUM_DISKS(3)) u3 (
        .clk(clk), .reset(rst3), .start(st3), .mv_valid(v3), .mv_ready(rdy3),
        .mv_from(f3), .mv_to(t3), .mv_disk(d3), .mv_index(i3),
        .busy(b3), .done(dn3), .illegal(il3));
    hanoi_move_gen #(.NUM_DISKS(2), .SRC_PEG(2), .DST_PEG(1)) u2 (
        .clk(clk), .reset(rst2), .start(st2), .mv_valid(v2), .mv_ready(rdy2),
        .mv_from(f2), .mv_to(t2), .mv_disk(d2), .mv_index(i2),
        .busy(b2), .done(dn2), .illegal(il2));
    hanoi_move_gen #(.NUM_DISKS(5)) u5 (
        .clk(clk), .reset(rst5), .start(st5), .mv_valid(v5), .mv_ready(rdy5),
        .mv_from(f5), .mv_to(t5), .mv_disk(d5), .mv_index(i5),
        .busy(b5), .done(dn5), .illegal(il5));
    hanoi_move_gen #(.NUM_DISKS(1)) u1 (
        .clk(clk), .reset(rst1), .start(st1), .mv_valid(v1), .mv_ready(rdy1),
        .mv_from(f1), .mv_to(t1), .mv_disk(d1), .mv_index(i1),
        .busy(b1), .done(dn1), .illegal(il1));

    int n3_from [7] = '{1, 1, 3, 1, 2, 2, 1};
    int n3_to   [7] = '{3, 2, 2, 3, 1, 3, 3};
    int n3_disk [7] = '{0, 1, 0, 2, 0, 1, 0};
    int n2_from [3] = '{2, 2, 3};
    int n2_to   [3] = '{3, 1, 1};
    int n2_disk [3] = '{0, 1, 0};

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_move3(input int i);
        check_value("n3_valid", 32'(v3), 1);
        check_value("n3_busy",  32'(b3), 1);
        check_value("n3_from",  32'(f3), n3_from[i]);
        check_value("n3_to",    32'(t3), n3_to[i]);
        check_value("n3_disk",  32'(d3), n3_disk[i]);
        check_value("n3_index", 32'(i3), i + 1);
    endtask

    task automatic run_n3(input int stall_k);
        @(negedge clk) st3 = 1'b1;
        @(negedge clk) st3 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i + 1 == stall_k) begin
                rdy3 = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check_move3(i);
                end
                rdy3 = 1'b1;
            end
            check_move3(i);
            check_value("n3_done_early", 32'(dn3), 0);
            @(negedge clk);
        end
        check_value("n3_done",      32'(dn3), 1);
        check_value("n3_fin_valid", 32'(v3), 0);
        check_value("n3_fin_busy",  32'(b3), 0);
        check_value("n3_fin_from",  32'(f3), 0);
        check_value("n3_fin_to",    32'(t3), 0);
        check_value("n3_fin_index", 32'(i3), 0);
        @(negedge clk);
        check_value("n3_done_pulse", 32'(dn3), 0);
        check_value("n3_illegal",    32'(il3), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int xfers;
        int dones;
        {rst3, rst2, rst5, rst1} = 4'hF;
        {st3, st2, st5, st1}     = 4'h0;
        {rdy3, rdy2, rdy5, rdy1} = 4'hF;
        repeat (3) @(negedge clk);
        check_value("rst_valid",   32'(v3), 0);
        check_value("rst_busy",    32'(b3), 0);
        check_value("rst_done",    32'(dn3), 0);
        check_value("rst_from",    32'(f3), 0);
        check_value("rst_to",      32'(t3), 0);
        check_value("rst_disk",    32'(d3), 0);
        check_value("rst_index",   32'(i3), 0);
        check_value("rst_illegal", 32'(il3), 0);
        {rst3, rst2, rst5, rst1} = 4'h0;
        @(negedge clk);

        // Free-running, then with a 5-cycle stall on move 4.
        run_n3(0);
        run_n3(4);

        // Non-default pegs.
        @(negedge clk) st2 = 1'b1;
        @(negedge clk) st2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_value("n2_valid", 32'(v2), 1);
            check_value("n2_from",  32'(f2), n2_from[i]);
            check_value("n2_to",    32'(t2), n2_to[i]);
            check_value("n2_disk",  32'(d2), n2_disk[i]);
            check_value("n2_index", 32'(i2), i + 1);
            @(negedge clk);
        end
        check_value("n2_done",  32'(dn2), 1);
        check_value("n2_valid_fin", 32'(v2), 0);

        // Five disks with an ignored restart at k=7.
        xfers = 0;
        dones = 0;
        @(negedge clk) st5 = 1'b1;
        @(negedge clk) st5 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (v5 && rdy5) xfers++;
            if (dn5) dones++;
            if (v5 && i5 == 5'd10) begin
                check_value("n5_k10_from", 32'(f5), 3);
                check_value("n5_k10_to",   32'(t5), 1);
                check_value("n5_k10_disk", 32'(d5), 1);
            end
            if (v5 && i5 == 5'd16) begin
                check_value("n5_k16_from", 32'(f5), 1);
                check_value("n5_k16_to",   32'(t5), 3);
                check_value("n5_k16_disk", 32'(d5), 4);
            end
            st5 = v5 && (i5 == 5'd7);
            @(negedge clk);
        end
        st5 = 1'b0;
        check_value("n5_transfers", 32'(xfers), 31);
        check_value("n5_dones",     32'(dones), 1);
        check_value("n5_illegal",   32'(il5), 0);
        check_value("n5_busy_end",  32'(b5), 0);

        // Reset during move k=10, then restart from scratch.
        @(negedge clk) st5 = 1'b1;
        @(negedge clk) st5 = 1'b0;
        for (int c = 0; c < 40 && !(v5 && i5 == 5'd10); c++) @(negedge clk);
        check_value("n5_reach_k10", 32'(i5), 10);
        rst5 = 1'b1;
        @(negedge clk) rst5 = 1'b0;
        check_value("n5_rst_valid", 32'(v5), 0);
        check_value("n5_rst_busy",  32'(b5), 0);
        check_value("n5_rst_done",  32'(dn5), 0);
        @(negedge clk);
        check_value("n5_rst_nodone", 32'(dn5), 0);
        st5 = 1'b1;
        @(negedge clk) st5 = 1'b0;
        check_value("n5_re_valid", 32'(v5), 1);
        check_value("n5_re_from",  32'(f5), 1);
        check_value("n5_re_to",    32'(t5), 3);
        check_value("n5_re_disk",  32'(d5), 0);
        check_value("n5_re_index", 32'(i5), 1);

        // Single disk, started twice.
        for (int rep = 0; rep < 2; rep++) begin
            @(negedge clk) st1 = 1'b1;
            @(negedge clk) st1 = 1'b0;
            check_value("n1_valid", 32'(v1), 1);
            check_value("n1_busy",  32'(b1), 1);
            check_value("n1_from",  32'(f1), 1);
            check_value("n1_to",    32'(t1), 3);
            check_value("n1_disk",  32'(d1), 0);
            check_value("n1_index", 32'(i1), 1);
            @(negedge clk);
            check_value("n1_done",      32'(dn1), 1);
            check_value("n1_fin_valid", 32'(v1), 0);
            check_value("n1_fin_busy",  32'(b1), 0);
            @(negedge clk);
            check_value("n1_done_pulse", 32'(dn1), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
